// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM arbiter: blanking-triggered line fetch into a double-banked line buffer, host gets the idle cycles.
// Optional VRAM_ARB_BLANK_ONLY_EN: host granted only while hblank|vblank is high.
module vram_arbiter #(
  parameter int LINE_WORDS = 200,
  parameter int V_LINES    = 600,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16
) (
  input  logic              clk_pixel,
  input  logic              reset,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [ADDR_W-1:0] lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_overrun
);

  localparam int WORD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LC_W   = $clog2(V_LINES + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t            state_q;
  logic              hblank_q, vblank_q;
  logic              frame_q;
  logic [LC_W-1:0]   next_line_q;
  logic              bank_q;
  logic [WORD_W-1:0] word_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic              lb_we_q;
  logic [ADDR_W-1:0] lb_addr_q;
  logic              rvalid_q;
  logic              overrun_q;

  logic              vb_rise, hb_rise, hb_trig, trig, busy, fetching, blank_ok;
  logic [LC_W-1:0]   fetch_line;
  logic [ADDR_W-1:0] fetch_base;

  assign vb_rise  = vblank & ~vblank_q;
  assign hb_rise  = hblank & ~hblank_q;
  // hblank fetches are only meaningful once a frame has been started by vblank
  assign hb_trig  = hb_rise & ~vblank & frame_q & (next_line_q < LC_W'(V_LINES));
  assign trig     = vb_rise | hb_trig;
  assign busy     = (state_q != S_IDLE);
  assign fetching = (state_q == S_FETCH);

  assign fetch_line = vb_rise ? '0 : next_line_q;
  assign fetch_base = ADDR_W'(fetch_line) * ADDR_W'(LINE_WORDS);

`ifdef VRAM_ARB_BLANK_ONLY_EN
  assign blank_ok = hblank | vblank;
`else
  assign blank_ok = 1'b1;
`endif

  // A trigger seen this cycle starts the burst immediately, so it also blocks the host
  assign host_ready = host_valid & ~reset & ~busy & ~trig & blank_ok;

  assign mem_re     = fetching | (host_ready & ~host_we);
  assign mem_we     = host_ready & host_we;
  assign mem_addr   = fetching ? fetch_addr_q : (host_ready ? host_addr : '0);
  assign mem_wdata  = mem_we ? host_wdata : '0;

  assign host_rvalid   = rvalid_q;
  assign host_rdata    = rvalid_q ? mem_rdata : '0;
  assign lb_we         = lb_we_q;
  assign lb_bank       = bank_q;
  assign lb_addr       = lb_addr_q;
  assign lb_wdata      = lb_we_q ? mem_rdata : '0;
  assign fetch_overrun = overrun_q;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q      <= S_IDLE;
      // Previous-level registers reset high so a blank already active at release is not a rise
      hblank_q     <= 1'b1;
      vblank_q     <= 1'b1;
      frame_q      <= 1'b0;
      next_line_q  <= '0;
      bank_q       <= 1'b0;
      word_q       <= '0;
      fetch_addr_q <= '0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
      rvalid_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      hblank_q  <= hblank;
      vblank_q  <= vblank;
      lb_we_q   <= fetching;
      lb_addr_q <= ADDR_W'(word_q);
      rvalid_q  <= host_ready & ~host_we;
      if (trig && busy) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (trig) begin
            state_q      <= S_FETCH;
            bank_q       <= ~bank_q;
            word_q       <= '0;
            fetch_addr_q <= fetch_base;
            next_line_q  <= vb_rise ? LC_W'(1) : next_line_q + LC_W'(1);
            if (vb_rise) frame_q <= 1'b1;
          end
        end
        S_FETCH: begin
          word_q       <= word_q + WORD_W'(1);
          fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
          if (word_q == WORD_W'(LINE_WORDS - 1)) state_q <= S_DRAIN;
        end
        S_DRAIN: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter with a 1-cycle-latency VRAM model.
module tb_vram_arbiter;

  localparam int LW = 4;
  localparam int VL = 3;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hblank = 1'b0, vblank = 1'b0;
  logic          host_valid = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ready, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          lb_we, lb_bank;
  logic [AW-1:0] lb_addr;
  logic [DW-1:0] lb_wdata;
  logic          fetch_overrun;

  vram_arbiter #(.LINE_WORDS(LW), .V_LINES(VL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_pixel(clk), .reset(reset), .hblank(hblank), .vblank(vblank),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr),
    .lb_wdata(lb_wdata), .fetch_overrun(fetch_overrun)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] vram    [16];
  logic [DW-1:0] exp_mem [16];

  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= vram[mem_addr];
  end

  int tests = 0;
  int fails = 0;

  logic [AW-1:0]        exp_rd   [$];
  logic [AW+DW-1:0]     exp_wr   [$];
  logic [1+AW+DW-1:0]   exp_lb   [$];
  logic [DW-1:0]        exp_host [$];

  logic [62:0] all_outs;
  assign all_outs = {host_ready, host_rvalid, host_rdata, mem_addr, mem_re, mem_we, mem_wdata,
                     lb_we, lb_bank, lb_addr, lb_wdata, fetch_overrun};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe
  always @(negedge clk) begin
    if (mem_re && mem_we) check("re_we_exclusive", 64'(mem_re & mem_we), 64'd0);
    if (mem_re) begin
      if (exp_rd.size() == 0) check("unexpected_mem_re", 64'(mem_addr), 64'hFFFF);
      else check("mem_re_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
    end
    if (mem_we) begin
      if (exp_wr.size() == 0) check("unexpected_mem_we", 64'({mem_addr, mem_wdata}), 64'hFFFFFF);
      else check("mem_we_addr_data", 64'({mem_addr, mem_wdata}), 64'(exp_wr.pop_front()));
    end
    if (lb_we) begin
      if (exp_lb.size() == 0) check("unexpected_lb_we", 64'({lb_bank, lb_addr, lb_wdata}), 64'hFFFFFFF);
      else check("lb_bank_addr_data", 64'({lb_bank, lb_addr, lb_wdata}), 64'(exp_lb.pop_front()));
    end
    if (host_rvalid) begin
      if (exp_host.size() == 0) check("unexpected_rvalid", 64'(host_rdata), 64'hFFFFF);
      else check("host_rdata", 64'(host_rdata), 64'(exp_host.pop_front()));
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_line(input int line, input logic bank);
    for (int w = 0; w < LW; w++) begin
      exp_rd.push_back(AW'(line * LW + w));
      exp_lb.push_back({bank, AW'(w), exp_mem[line * LW + w]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waited;
    int got;
    int re_cnt;
    for (int i = 0; i < 16; i++) begin
      vram[i]    = 16'hA000 + 16'(i);
      exp_mem[i] = 16'hA000 + 16'(i);
    end

    // Reset state
    cyc(9);
    @(negedge clk);
    check("reset_outputs", 64'(all_outs), 64'd0);
    cyc(1);
    reset = 1'b0;
    cyc(2);

    // Line 0 on vblank rise, bank 1
    push_line(0, 1'b1);
    vblank = 1'b1;
    cyc(10);
    @(negedge clk);
    check("overrun_clear", 64'(fetch_overrun), 64'd0);
    cyc(1);

    // Three hblank rises: lines 1, 2, then nothing
    vblank = 1'b0;
    cyc(2);
    push_line(1, 1'b0);
    push_line(2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      hblank = 1'b1;
      cyc(2);
      if (k < 2) begin
        hblank = 1'b0;
        cyc(8);
      end
    end
    cyc(8);

    // Host write then read of address 5 (hblank held high)
    exp_wr.push_back({AW'(5), 16'hBEEF});
    exp_mem[5] = 16'hBEEF;
    host_valid = 1'b1; host_we = 1'b1; host_addr = AW'(5); host_wdata = 16'hBEEF;
    @(negedge clk);
    check("host_ready_write", 64'(host_ready), 64'd1);
    cyc(1);
    exp_rd.push_back(AW'(5));
    exp_host.push_back(16'hBEEF);
    host_we = 1'b0; host_wdata = '0;
    @(negedge clk);
    check("host_ready_read", 64'(host_ready), 64'd1);
    cyc(1);
    host_valid = 1'b0;
    cyc(3);

    // Host read held across a burst: fetch wins, host waits at most LW+2 cycles
    push_line(0, 1'b0);
    exp_rd.push_back(AW'(2));
    exp_host.push_back(exp_mem[2]);
    hblank = 1'b0; vblank = 1'b1;
    host_valid = 1'b1; host_we = 1'b0; host_addr = AW'(2);
    waited = 0; got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (host_ready) got = 1;
      else waited++;
    end
    check("host_accepted", 64'(got), 64'd1);
    check("host_wait_bound", 64'((waited >= LW) && (waited <= LW + 2)), 64'd1);
    @(posedge clk); #1;
    host_valid = 1'b0;
    cyc(3);

    // hblank rise during FETCH: overrun set, next_line still 2 afterwards
    vblank = 1'b0;
    cyc(3);
    push_line(1, 1'b1);
    hblank = 1'b1;
    cyc(1);
    hblank = 1'b0;
    cyc(1);
    hblank = 1'b1;
    cyc(8);
    @(negedge clk);
    check("overrun_set", 64'(fetch_overrun), 64'd1);
    cyc(1);
    hblank = 1'b0;
    cyc(2);
    push_line(2, 1'b0);
    hblank = 1'b1;
    cyc(8);
    @(negedge clk);
    check("overrun_sticky", 64'(fetch_overrun), 64'd1);
    cyc(1);

    // Reset mid-burst
    exp_rd.push_back(AW'(0));
    exp_rd.push_back(AW'(1));
    exp_lb.push_back({1'b1, AW'(0), exp_mem[0]});
    hblank = 1'b0; vblank = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    @(negedge clk);
    check("reset_midburst_outputs", 64'(all_outs), 64'd0);
    cyc(1);
    reset = 1'b0;
    vblank = 1'b0;
    cyc(2);
    hblank = 1'b1;
    cyc(1);
    hblank = 1'b0;
    re_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_re) re_cnt++;
    end
    check("no_fetch_before_vblank", 64'(re_cnt), 64'd0);
    cyc(1);

    // Host during active video
    host_valid = 1'b1; host_we = 1'b1; host_addr = AW'(9); host_wdata = 16'h1234;
`ifdef VRAM_ARB_BLANK_ONLY_EN
    @(negedge clk);
    check("host_ready_active_video", 64'(host_ready), 64'd0);
`else
    exp_wr.push_back({AW'(9), 16'h1234});
    exp_mem[9] = 16'h1234;
    @(negedge clk);
    check("host_ready_active_video", 64'(host_ready), 64'd1);
`endif
    cyc(1);
    host_valid = 1'b0;
    cyc(2);

    // Fetch resumes on the next vblank rise, bank restarts from 0 -> 1
    push_line(0, 1'b1);
    vblank = 1'b1;
    cyc(10);

    check("exp_rd_drained", 64'(exp_rd.size()), 64'd0);
    check("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
    check("exp_lb_drained", 64'(exp_lb.size()), 64'd0);
    check("exp_host_drained", 64'(exp_host.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
